sobel_edge_filter: RTL and testbench
====================================

Name: sobel_edge_filter

Overview:
- Downstream neighbour of the RGB-to-gray stage. Consumes its gray pixel stream (valid + 8-bit value) in raster order.
- Applies a 3x3 Sobel operator and emits one 8-bit edge magnitude per interior pixel for the Avalon-side writer.
- Holds two image-row line buffers. A small FSM frames each image: start, run, drain, done.

Parameters:
- IMG_W, 256, image width in pixels; must be >= 3.
- IMG_H, 256, image height in rows; must be >= 3.
- THRESH, 0, 0 gives saturated magnitude output; nonzero gives binary output (255 if magnitude >= THRESH, else 0).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; begins (or restarts) a frame.
- valid_i  in  1  GrayColor_i holds a pixel this cycle; no backpressure.
- GrayColor_i  in  8  gray pixel, unsigned.
- valid_o  out  1  EdgeColor_o valid this cycle.
- EdgeColor_o  out  8  edge magnitude, unsigned.
- done_o  out  1  one-cycle pulse after the last interior output of the frame.

Behaviour:
- Reset (rst_i high at an edge): FSM goes to IDLE; col/row counters = 0; pipeline valid bits = 0; valid_o = 0, EdgeColor_o = 0, done_o = 0. Line-buffer contents are don't-care.
- FSM states:
  - IDLE: valid_i ignored. start_i moves to RUN and clears counters.
  - RUN: each valid_i high accepts one pixel. When pixel (IMG_H-1, IMG_W-1) is accepted, move to FLUSH.
  - FLUSH: wait 2 cycles for the pipeline to drain, then go to DONE.
  - DONE: done_o = 1 for exactly one cycle, then IDLE.
- valid_i in the same cycle as start_i is ignored. Pixels are accepted from the following cycle onward.
- Counters: col wraps IMG_W-1 -> 0 and increments row; both advance only on accepted pixels. Gaps in valid_i stall everything without losing state.
- Line buffers: two IMG_W-deep x 8 buffers, addressed by col.
  - On accept: read old row-1 and row-2 values at col; write the new pixel into buffer A; write buffer A's old value into buffer B.
- Window: 3x3 register array that shifts left on accept. New column = {B_old, A_old, GrayColor_i} (top to bottom).
- Output generation: an output is produced for accepted pixel (r,c) only when r >= 2 and c >= 2. It is centred at (r-1,c-1), giving (IMG_W-2)*(IMG_H-2) outputs per frame.
- Arithmetic (p[row][col], row 0 = top):
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), 11-bit signed.
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02), 11-bit signed.
  - mag = |Gx| + |Gy|, 12-bit unsigned, max 2040.
  - THRESH = 0: EdgeColor_o = min(mag, 255).
  - THRESH != 0: EdgeColor_o = (mag >= THRESH) ? 255 : 0.
- Pipeline: edge k samples the pixel and updates the window. Edge k+1 registers |Gx| and |Gy|. Edge k+2 registers the output.
  - valid_o is high for exactly the cycle after edge k+2 and is otherwise 0.
  - EdgeColor_o holds its last value when valid_o = 0.
  - Stages 2 and 3 advance every cycle, independent of valid_i.
- start_i while in RUN or FLUSH: the frame restarts.
  - Counters clear and pipeline valid bits clear, so no stale outputs appear.
  - No done_o is issued for the aborted frame.
- start_i in DONE is ignored.
- Reset mid-frame: same as a power-up reset; no done_o.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN, FLUSH, DONE);
  - PIX_W = 8;
  - PIX_MAX = 255;
  - GRAD_W = 11;
  - MAG_W = 12.
- Natural sub-module: sobel_line_buffer. It is a single IMG_W x 8 RAM with read-before-write at one address; instantiate it twice.
- FSM, counters, window and arithmetic stay in the top module.

Test Plan:
- 4x4 frame, all pixels 100, continuous valid_i -> 4 outputs, each 0; done_o pulses 3 cycles after the last accepted pixel.
- 4x4 horizontal ramp, pixel = 10*col -> 4 outputs, each 80 (Gx = 80, Gy = 0).
- 5x5 vertical step, cols 0-1 = 0, cols 2-4 = 255:
  - THRESH = 0 -> centre-col 1 and 2 outputs = 255 (saturated from 1020), centre-col 3 outputs = 0.
  - THRESH = 200 -> same positions give 255 / 255 / 0.
- Ramp frame with a random 1-3 cycle valid_i gap after every pixel -> same 4 values of 80; valid_o exactly 2 cycles after each producing pixel's sampling edge.
- Reset case: rst_i after 7 pixels of a 4x4 frame, then a fresh frame -> no outputs or done_o from the aborted frame; the new frame gives correct results.
- Restart case: start_i after 9 pixels of a 4x4 frame, then a fresh frame -> no outputs or done_o from the aborted frame; the new frame gives correct results.

Source files
------------

// File: rtl/sobel_edge_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_filter_pkg
// Description : Shared constants, FSM state encoding and small arithmetic
//               helpers for the Sobel edge filter.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_edge_filter_pkg;

    // Pixel and arithmetic widths
    localparam int PIX_W   = 8;
    localparam int PIX_MAX = 255;
    localparam int GRAD_W  = 11;   // signed gradient, range [-1020, 1020]
    localparam int MAG_W   = 12;   // |Gx| + |Gy|, max 2040

    // Frame-sequencing FSM encoding
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] c_ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] c_ST_FLUSH = 2'd2;
    localparam logic [STATE_W-1:0] c_ST_DONE  = 2'd3;

    // a + 2*b + c for one Sobel column/row tap set; max 1020 so it never
    // touches the sign bit of a GRAD_W-wide result.
    function automatic logic [GRAD_W-1:0] weighted_sum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        return GRAD_W'(a) + GRAD_W'({b, 1'b0}) + GRAD_W'(c);
    endfunction

    // Absolute value of a two's-complement gradient held in a plain vector.
    // The operand never reaches -1024, so the result always fits.
    function automatic logic [GRAD_W-1:0] abs_grad(input logic [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? (~g + 1'b1) : g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_line_buffer
// Description : One image row of pixel storage. Combinational read of the
//               addressed location and synchronous write to that same
//               location, so a read in the write cycle returns the old value
//               (read-before-write).
// Ports       : clk       - clock, write on rising edge
//               i_wr_en   - write enable
//               i_addr    - read/write address (pixel column)
//               i_wr_data - data to store
//               o_rd_data - current contents of i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_buffer #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Contents are never reset; every location is rewritten by a frame
    // before the window ever consumes it.
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/sobel_edge_filter.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_filter
// Description : 3x3 Sobel edge filter on a raster-order 8-bit gray stream.
//               Two line buffers plus a 3x3 window feed a two-stage
//               arithmetic pipeline (|Gx|,|Gy| then magnitude/threshold).
//               A small FSM frames each image: IDLE, RUN, FLUSH, DONE.
// Ports       : clk_i       - clock, rising edge
//               rst_i       - synchronous active-high reset
//               start_i     - one-cycle pulse, starts or restarts a frame
//               valid_i     - GrayColor_i carries a pixel this cycle
//               GrayColor_i - gray pixel, unsigned
//               valid_o     - EdgeColor_o valid this cycle
//               EdgeColor_o - edge magnitude (or binary edge map)
//               done_o      - one-cycle pulse after the frame's last output
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_edge_filter
    import sobel_edge_filter_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int THRESH = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [PIX_W-1:0] GrayColor_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] EdgeColor_o,
    output logic             done_o
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] c_COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_ROW_TWO  = ROW_W'(2);
    localparam logic [31:0]      c_THRESH   = 32'(THRESH);
    localparam bit               c_BINARY   = (THRESH != 0);
    localparam logic [MAG_W-1:0] c_MAG_SAT  = MAG_W'(PIX_MAX);

    // ------------------------------------------------------------------
    // Control signals
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               r_flush_cnt;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;

    logic w_start;      // start that actually takes effect (not in DONE)
    logic w_accept;     // pixel consumed this cycle
    logic w_col_last;
    logic w_last_pix;   // final pixel of the frame consumed
    logic w_produce;    // accepted pixel completes an interior window

    // start_i is ignored in DONE; everywhere else it (re)starts a frame.
    assign w_start    = start_i && (r_state != c_ST_DONE);
    // A pixel arriving alongside start_i belongs to no frame.
    assign w_accept   = (r_state == c_ST_RUN) && valid_i && !start_i;
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_last_pix = w_accept && w_col_last && (r_row == c_ROW_LAST);
    assign w_produce  = w_accept && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_flush_cnt <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else begin
                r_flush_cnt <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (start_i) begin
                    w_state_next = c_ST_RUN;
                end else if (w_last_pix) begin
                    w_state_next = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                // Two cycles let the last window pass both arithmetic stages.
                if (start_i) begin
                    w_state_next = c_ST_RUN;
                end else if (r_flush_cnt) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Column / row counters: advance only on accepted pixels
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: A holds row r-1, B holds row r-2 at each column.
    // On accept the new pixel goes into A and A's old value moves to B.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_buf_a_rd;
    logic [PIX_W-1:0] w_buf_b_rd;

    sobel_line_buffer #(
        .DEPTH  (IMG_W),
        .WIDTH  (PIX_W),
        .ADDR_W (COL_W)
    ) u_buf_a (
        .clk       (clk_i),
        .i_wr_en   (w_accept),
        .i_addr    (r_col),
        .i_wr_data (GrayColor_i),
        .o_rd_data (w_buf_a_rd)
    );

    sobel_line_buffer #(
        .DEPTH  (IMG_W),
        .WIDTH  (PIX_W),
        .ADDR_W (COL_W)
    ) u_buf_b (
        .clk       (clk_i),
        .i_wr_en   (w_accept),
        .i_addr    (r_col),
        .i_wr_data (w_buf_a_rd),
        .o_rd_data (w_buf_b_rd)
    );

    // ------------------------------------------------------------------
    // 3x3 window, r_win[row][col], row 0 = top, col 2 = newest column
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] r_win [0:2][0:2];
    logic             r_win_v;

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_buf_b_rd;
            r_win[1][2] <= w_buf_a_rd;
            r_win[2][2] <= GrayColor_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_win_v <= 1'b0;
        end else begin
            r_win_v <= w_produce;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: gradients. The differences are taken modulo 2^GRAD_W,
    // which is exact because each result lies in [-1020, 1020].
    // ------------------------------------------------------------------
    logic [GRAD_W-1:0] w_gx;
    logic [GRAD_W-1:0] w_gy;
    logic [GRAD_W-1:0] r_abs_gx;
    logic [GRAD_W-1:0] r_abs_gy;
    logic              r_grad_v;

    always_comb begin
        w_gx = weighted_sum(r_win[0][2], r_win[1][2], r_win[2][2])
             - weighted_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
        w_gy = weighted_sum(r_win[2][0], r_win[2][1], r_win[2][2])
             - weighted_sum(r_win[0][0], r_win[0][1], r_win[0][2]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grad_v <= 1'b0;
            r_abs_gx <= '0;
            r_abs_gy <= '0;
        end else begin
            r_grad_v <= w_start ? 1'b0 : r_win_v;
            r_abs_gx <= abs_grad(w_gx);
            r_abs_gy <= abs_grad(w_gy);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, then saturate or threshold
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] w_mag;
    logic [PIX_W-1:0] w_edge;
    logic [PIX_W-1:0] r_edge;
    logic             r_out_v;
    logic             r_done;

    always_comb begin
        w_mag = MAG_W'(r_abs_gx) + MAG_W'(r_abs_gy);
        if (c_BINARY) begin
            w_edge = (32'(w_mag) >= c_THRESH) ? PIX_W'(PIX_MAX) : '0;
        end else begin
            w_edge = (w_mag > c_MAG_SAT) ? PIX_W'(PIX_MAX) : w_mag[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_v <= 1'b0;
            r_edge  <= '0;
        end else begin
            r_out_v <= w_start ? 1'b0 : r_grad_v;
            // Data only moves with a live result, so it holds between outputs.
            if (r_grad_v && !w_start) begin
                r_edge <= w_edge;
            end
        end
    end

    // DONE is entered on the same edge as the final output; registering it
    // places the pulse one cycle after that output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_ST_DONE);
        end
    end

    assign valid_o     = r_out_v;
    assign EdgeColor_o = r_edge;
    assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_edge_filter
// Description : Directed self-checking bench for sobel_edge_filter. Three
//               instances (4x4, 5x5, 5x5 with THRESH=200) share the stimulus;
//               only the selected instance is observed in each test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       valid;
    logic [7:0] gray;

    logic       v0, v1, v2;
    logic       d0, d1, d2;
    logic [7:0] e0, e1, e2;

    always #5 clk = ~clk;

    sobel_edge_filter #(.IMG_W(4), .IMG_H(4), .THRESH(0)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .GrayColor_i(gray), .valid_o(v0), .EdgeColor_o(e0), .done_o(d0));

    sobel_edge_filter #(.IMG_W(5), .IMG_H(5), .THRESH(0)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .GrayColor_i(gray), .valid_o(v1), .EdgeColor_o(e1), .done_o(d1));

    sobel_edge_filter #(.IMG_W(5), .IMG_H(5), .THRESH(200)) u_dut5t (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .GrayColor_i(gray), .valid_o(v2), .EdgeColor_o(e2), .done_o(d2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sel = 0;
    int out_val[$];
    int out_cyc[$];
    int done_cyc[$];
    int exp_edges[$];
    int last_edge = 0;
    int checks = 0;
    int failures = 0;

    function automatic logic sel_valid();
        return (sel == 0) ? v0 : (sel == 1) ? v1 : v2;
    endfunction
    function automatic logic sel_done();
        return (sel == 0) ? d0 : (sel == 1) ? d1 : d2;
    endfunction
    function automatic int sel_edge();
        return (sel == 0) ? int'(e0) : (sel == 1) ? int'(e1) : int'(e2);
    endfunction

    // Monitor: cyc at this negedge equals the index of the preceding posedge
    always @(negedge clk) begin
        if (sel_valid()) begin
            out_val.push_back(sel_edge());
            out_cyc.push_back(cyc);
        end
        if (sel_done()) done_cyc.push_back(cyc);
    end

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return 10 * c;
            2: return (c < 2) ? 0 : 255;
            3: return 10 * r;
            4: return 20 * r + 10 * c;
            5: return 200 - 30 * c;
            6: return 25 * c;
            7: return 32 * c;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_q();
        out_val.delete(); out_cyc.delete(); done_cyc.delete(); exp_edges.delete();
    endtask

    // Start pulse carries a junk pixel that must be ignored
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; valid = 1'b1; gray = 8'd77;
    endtask

    task automatic feed(input int kind, input int w, input bit gaps, input int count);
        int idx;
        idx = 0;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (idx < count) begin
                    @(negedge clk);
                    start = 1'b0; valid = 1'b1; gray = 8'(pix(kind, r, c));
                    last_edge = cyc + 1;
                    if (r >= 2 && c >= 2) exp_edges.push_back(cyc + 3);
                    if (gaps) begin
                        int n;
                        n = int'($urandom_range(1, 3));
                        @(negedge clk);
                        valid = 1'b0;
                        repeat (n - 1) @(negedge clk);
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int w, input int le,
                               input int x0, input int x1, input int x2);
        int n;
        int ex;
        n = (w - 2) * (w - 2);
        chk($sformatf("%s_count", tag), out_val.size(), n);
        for (int i = 0; i < n; i++) begin
            ex = ((i % (w - 2)) == 0) ? x0 : ((i % (w - 2)) == 1) ? x1 : x2;
            if (i < out_val.size()) begin
                chk($sformatf("%s_val%0d", tag, i), out_val[i], ex);
                chk($sformatf("%s_lat%0d", tag, i), out_cyc[i], exp_edges[i]);
            end
        end
        chk($sformatf("%s_done_count", tag), done_cyc.size(), 1);
        if (done_cyc.size() > 0)
            chk($sformatf("%s_done_time", tag), done_cyc[0], le + 3);
        ex = (((n - 1) % (w - 2)) == 0) ? x0 : (((n - 1) % (w - 2)) == 1) ? x1 : x2;
        chk($sformatf("%s_hold", tag), sel_edge(), ex);
    endtask

    typedef struct packed {
        logic [1:0] dut;
        logic [2:0] kind;
        logic       gaps;
        logic [7:0] x0;
        logic [7:0] x1;
        logic [7:0] x2;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int le;
        rst = 1'b0; start = 1'b0; valid = 1'b0; gray = 8'd0;

        //            dut   kind  gaps  ctr-col 1/2/3 expected
        vecs[0]  = '{2'd0, 3'd0, 1'b0, 8'd0,   8'd0,   8'd0};   // flat
        vecs[1]  = '{2'd0, 3'd1, 1'b0, 8'd80,  8'd80,  8'd0};   // ramp Gx=80
        vecs[2]  = '{2'd1, 3'd2, 1'b0, 8'd255, 8'd255, 8'd0};   // step, saturate
        vecs[3]  = '{2'd2, 3'd2, 1'b0, 8'd255, 8'd255, 8'd0};   // step, thresh
        vecs[4]  = '{2'd0, 3'd1, 1'b1, 8'd80,  8'd80,  8'd0};   // ramp w/ gaps
        vecs[5]  = '{2'd0, 3'd3, 1'b0, 8'd80,  8'd80,  8'd0};   // Gy=80
        vecs[6]  = '{2'd0, 3'd4, 1'b0, 8'd240, 8'd240, 8'd0};   // 80+160
        vecs[7]  = '{2'd0, 3'd5, 1'b0, 8'd240, 8'd240, 8'd0};   // Gx=-240
        vecs[8]  = '{2'd2, 3'd1, 1'b0, 8'd0,   8'd0,   8'd0};   // 80 < 200
        vecs[9]  = '{2'd1, 3'd6, 1'b0, 8'd200, 8'd200, 8'd200}; // 200 unsat
        vecs[10] = '{2'd2, 3'd6, 1'b0, 8'd255, 8'd255, 8'd255}; // mag == THRESH
        vecs[11] = '{2'd1, 3'd7, 1'b0, 8'd255, 8'd255, 8'd255}; // 256 saturates

        do_reset();
        @(negedge clk);
        chk("rst_valid0", int'(v0), 0); chk("rst_edge0", int'(e0), 0); chk("rst_done0", int'(d0), 0);
        chk("rst_valid1", int'(v1), 0); chk("rst_edge1", int'(e1), 0); chk("rst_done1", int'(d1), 0);
        chk("rst_valid2", int'(v2), 0); chk("rst_edge2", int'(e2), 0); chk("rst_done2", int'(d2), 0);

        for (int vi = 0; vi < 12; vi++) begin
            w = (vecs[vi].dut == 2'd0) ? 4 : 5;
            sel = int'(vecs[vi].dut);
            do_reset();
            clear_q();
            pulse_start();
            feed(int'(vecs[vi].kind), w, vecs[vi].gaps, w * w);
            idle(8);
            check_frame($sformatf("v%0d", vi), w, last_edge,
                        int'(vecs[vi].x0), int'(vecs[vi].x1), int'(vecs[vi].x2));
        end

        // Reset after 7 pixels, then a fresh frame
        sel = 0;
        do_reset();
        clear_q();
        pulse_start();
        feed(1, 4, 1'b0, 7);
        @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);
        chk("rst_abort_outputs", out_val.size(), 0);
        chk("rst_abort_done", done_cyc.size(), 0);
        clear_q();
        pulse_start();
        feed(1, 4, 1'b0, 16);
        idle(8);
        check_frame("rst_new", 4, last_edge, 80, 80, 0);

        // Restart after 9 pixels; the restart pulse begins the fresh frame
        do_reset();
        clear_q();
        pulse_start();
        feed(0, 4, 1'b0, 9);
        exp_edges.delete();
        pulse_start();
        feed(1, 4, 1'b0, 16);
        idle(8);
        check_frame("restart9", 4, last_edge, 80, 80, 0);

        // Restart right after pixel (2,2) while its result is in flight
        do_reset();
        clear_q();
        pulse_start();
        feed(0, 4, 1'b0, 11);
        exp_edges.delete();
        pulse_start();
        feed(1, 4, 1'b0, 16);
        idle(8);
        check_frame("restart11", 4, last_edge, 80, 80, 0);

        // start_i while in DONE is ignored, so a following frame is dropped
        do_reset();
        clear_q();
        pulse_start();
        feed(1, 4, 1'b0, 16);
        le = last_edge;
        idle(2);
        pulse_start();
        feed(0, 4, 1'b0, 16);
        idle(8);
        check_frame("done_start", 4, le, 80, 80, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
